// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W              = 32;
    localparam int unsigned DEFAULT_DEPTH_WORDS = 256;
    localparam int unsigned DEFAULT_LATENCY     = 2;
    localparam int unsigned CNT_W               = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide backing store: synchronous write, synchronous registered read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // NOTE: the storage array has no reset so it maps onto RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: fixed-latency load/store service with a
// stall handshake (Ready) and an address-error pulse at completion.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] Adress,
    input  logic [WORD_W-1:0] WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [WORD_W-1:0] ReadData,
    output logic              Ready,
    output logic              AddrErr
);

    localparam int unsigned     IDX_W    = idx_width(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              rd_zero_q, rd_zero_d;

    logic              req;
    logic              commit;
    logic [WORD_W-1:0] cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic              cur_rd;
    logic              cur_wr;
    logic              cur_err;
    logic [WORD_W-1:0] arr_rdata;

    assign req = MemRead | MemWrite;

    // With LATENCY=1 the commit edge is the accept edge, so the live inputs are used in IDLE.
    assign cur_addr  = (state_q == IDLE) ? Adress    : addr_q;
    assign cur_wdata = (state_q == IDLE) ? WriteData : wdata_q;
    assign cur_rd    = (state_q == IDLE) ? MemRead   : rd_q;
    assign cur_wr    = (state_q == IDLE) ? MemWrite  : wr_q;

    assign cur_err = (|cur_addr[1:0])
                   | (|cur_addr[WORD_W-1:IDX_W+2])
                   | (cur_rd & cur_wr);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        err_d     = 1'b0;
        rd_zero_d = rd_zero_q;
        Ready     = 1'b0;
        commit    = 1'b0;

        unique case (state_q)
            IDLE: begin
                Ready = !req;
                if (req) begin
                    addr_d  = Adress;
                    wdata_d = WriteData;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    cnt_d   = CNT_INIT;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE: begin
                Ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            err_d = cur_err;
            if (cur_err) begin
                rd_zero_d = 1'b1;
            end else if (cur_rd) begin
                rd_zero_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            rd_zero_q <= rd_zero_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (commit & cur_wr & ~cur_err),
        .re_i    (commit & cur_rd & ~cur_err),
        .idx_i   (cur_addr[IDX_W+1:2]),
        .wdata_i (cur_wdata),
        .rdata_o (arr_rdata)
    );

    // ReadData is zero after reset or any errored access, until the next good load.
    assign ReadData = rd_zero_q ? '0 : arr_rdata;
    assign AddrErr  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for function and
// error cases, and a LATENCY=1 instance for back-to-back traffic.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic [31:0] Adress, WriteData, ReadData;
    logic        MemRead, MemWrite, Ready, AddrErr;

    logic [31:0] Adress1, WriteData1, ReadData1;
    logic        MemRead1, MemWrite1, Ready1, AddrErr1;

    int checks;
    int errors;

    logic [31:0] vals [3];

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .Adress    (Adress),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .Ready     (Ready),
        .AddrErr   (AddrErr)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .Adress    (Adress1),
        .WriteData (WriteData1),
        .MemRead   (MemRead1),
        .MemWrite  (MemWrite1),
        .ReadData  (ReadData1),
        .Ready     (Ready1),
        .AddrErr   (AddrErr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One LATENCY=2 access on dut2, started at a falling edge; checks stall
    // length, the DONE-cycle outputs and that AddrErr drops afterwards.
    task automatic acc2(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic eerr, input logic [31:0] erd);
        int lows;
        MemRead   = rd;
        MemWrite  = wr;
        Adress    = a;
        WriteData = wd;
        #1;
        lows = 0;
        while (Ready !== 1'b1 && lows < 20) begin
            lows++;
            @(negedge clk);
            #1;
        end
        check({tag, "_lows"}, 32'(lows), 32'd2);
        check({tag, "_err"},  {31'd0, AddrErr}, {31'd0, eerr});
        check({tag, "_rd"},   ReadData, erd);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_idle_rdy"}, {31'd0, Ready}, 32'd1);
        check({tag, "_idle_err"}, {31'd0, AddrErr}, 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        vals[0]    = 32'h0101_0101;
        vals[1]    = 32'h0202_0202;
        vals[2]    = 32'h0303_0303;
        rst_n      = 1'b0;
        Adress     = '0;
        WriteData  = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Adress1    = '0;
        WriteData1 = '0;
        MemRead1   = 1'b0;
        MemWrite1  = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_rd",  ReadData, 32'h0);
        check("rst_err", {31'd0, AddrErr}, 32'd0);
        check("rst_rdy", {31'd0, Ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_rdy", {31'd0, Ready}, 32'd1);
        @(negedge clk);

        acc2("st10",   1'b0, 1'b1, 32'h10,  32'hDEAD_BEEF, 1'b0, 32'h0);
        acc2("ld10",   1'b1, 1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF);
        acc2("st20",   1'b0, 1'b1, 32'h20,  32'h1234_5678, 1'b0, 32'hDEAD_BEEF);
        acc2("ld13",   1'b1, 1'b0, 32'h13,  32'h0,         1'b1, 32'h0);
        acc2("st22",   1'b0, 1'b1, 32'h22,  32'hFFFF_FFFF, 1'b1, 32'h0);
        acc2("ld20",   1'b1, 1'b0, 32'h20,  32'h0,         1'b0, 32'h1234_5678);
        acc2("st00",   1'b0, 1'b1, 32'h0,   32'hA5A5_A5A5, 1'b0, 32'h1234_5678);
        acc2("st400",  1'b0, 1'b1, 32'h400, 32'h1111_1111, 1'b1, 32'h0);
        acc2("ld00",   1'b1, 1'b0, 32'h0,   32'h0,         1'b0, 32'hA5A5_A5A5);

        // Store to the top word; inputs move during WAIT and must be ignored.
        MemWrite  = 1'b1;
        Adress    = 32'h3FC;
        WriteData = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        check("top_wait_rdy", {31'd0, Ready}, 32'd0);
        Adress    = 32'h0;
        WriteData = 32'h0;
        @(negedge clk);
        #1;
        check("top_done_rdy", {31'd0, Ready}, 32'd1);
        check("top_done_err", {31'd0, AddrErr}, 32'd0);
        check("top_done_rd",  ReadData, 32'hA5A5_A5A5);
        MemWrite = 1'b0;
        @(negedge clk);
        acc2("ld3fc",  1'b1, 1'b0, 32'h3FC, 32'h0,         1'b0, 32'hCAFE_F00D);
        acc2("ld00b",  1'b1, 1'b0, 32'h0,   32'h0,         1'b0, 32'hA5A5_A5A5);

        acc2("conf",   1'b1, 1'b1, 32'h10,  32'h0,         1'b1, 32'h0);
        acc2("ld10b",  1'b1, 1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF);

        // Store aborted by reset while in WAIT.
        MemWrite  = 1'b1;
        Adress    = 32'h20;
        WriteData = 32'hBAD0_BAD0;
        @(negedge clk);
        #1;
        check("abort_wait_rdy", {31'd0, Ready}, 32'd0);
        rst_n    = 1'b0;
        MemWrite = 1'b0;
        #1;
        check("abort_rst_rdy", {31'd0, Ready}, 32'd1);
        check("abort_rst_rd",  ReadData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("abort_idle_rdy", {31'd0, Ready}, 32'd1);
        check("abort_idle_err", {31'd0, AddrErr}, 32'd0);
        @(negedge clk);
        acc2("ld20b",  1'b1, 1'b0, 32'h20,  32'h0,         1'b0, 32'h1234_5678);

        // LATENCY=1: back-to-back stores then back-to-back loads.
        MemWrite1  = 1'b1;
        Adress1    = 32'h0;
        WriteData1 = vals[0];
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("b2b_st%0d_stall", i), {31'd0, Ready1}, 32'd0);
            @(negedge clk);
            #1;
            check($sformatf("b2b_st%0d_done", i), {31'd0, Ready1}, 32'd1);
            check($sformatf("b2b_st%0d_err", i),  {31'd0, AddrErr1}, 32'd0);
            check($sformatf("b2b_st%0d_rd", i),   ReadData1, 32'h0);
            if (i < 2) begin
                Adress1    = 32'(4 * (i + 1));
                WriteData1 = vals[i + 1];
            end else begin
                MemWrite1 = 1'b0;
            end
            @(negedge clk);
        end

        MemRead1   = 1'b1;
        Adress1    = 32'h0;
        WriteData1 = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("b2b_ld%0d_stall", i), {31'd0, Ready1}, 32'd0);
            @(negedge clk);
            #1;
            check($sformatf("b2b_ld%0d_done", i), {31'd0, Ready1}, 32'd1);
            check($sformatf("b2b_ld%0d_err", i),  {31'd0, AddrErr1}, 32'd0);
            check($sformatf("b2b_ld%0d_rd", i),   ReadData1, vals[i]);
            if (i < 2) begin
                Adress1 = 32'(4 * (i + 1));
            end else begin
                MemRead1 = 1'b0;
            end
            @(negedge clk);
        end
        #1;
        check("b2b_end_rdy", {31'd0, Ready1}, 32'd1);
        check("b2b_end_rd",  ReadData1, vals[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
